// File: rtl/phase_timer.sv
// Pausable tick prescaler plus a loadable phase timer that pulses done when a phase expires.
// Optional near-expiry flag `warn` is built only when PHASE_TIMER_WARN_EN is defined; otherwise it is tied low.
module phase_timer #(
  parameter int CLK_DIV  = 5,
  parameter int DIV_W    = 26,
  parameter int CNT_W    = 8,
  parameter int WARN_CNT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] duration,
  input  logic             pause,
  output logic             tick_o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining,
  output logic             warn
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [DIV_W-1:0] PRESC_RELOAD = DIV_W'(CLK_DIV - 1);

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] presc_reg, presc_next;
  logic             tick_reg, tick_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             tick_edge;
  logic             load_phase;

  // tick_edge is the edge on which tick_o rises and a running phase loses one tick
  assign tick_edge  = !pause && (presc_reg == '0);
  assign load_phase = start && (duration != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      presc_reg     <= PRESC_RELOAD;
      tick_reg      <= 1'b0;
      remaining_reg <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      presc_reg     <= presc_next;
      tick_reg      <= tick_next;
      remaining_reg <= remaining_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start)
          state_next = (duration != '0) ? RUN : DONE;
        else
          state_next = IDLE;
      end
      RUN: begin
        if (start)
          state_next = (duration != '0) ? RUN : DONE;
        else if (tick_edge && remaining_reg == CNT_W'(1))
          state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered: compute the values they take after this edge.
  always_comb begin
    presc_next     = presc_reg;
    tick_next      = tick_edge;
    remaining_next = '0;
    busy_next      = 1'b0;
    done_next      = 1'b0;

    // A new phase realigns the prescaler so its first tick is a full period away
    if (load_phase)
      presc_next = PRESC_RELOAD;
    else if (pause)
      presc_next = presc_reg;
    else if (presc_reg == '0)
      presc_next = PRESC_RELOAD;
    else
      presc_next = presc_reg - DIV_W'(1);

    case (state_next)
      RUN: begin
        busy_next = 1'b1;
        if (load_phase)
          remaining_next = duration;
        else if (tick_edge)
          remaining_next = remaining_reg - CNT_W'(1);
        else
          remaining_next = remaining_reg;
      end
      DONE:    done_next = 1'b1;
      default: ;
    endcase
  end

  assign tick_o    = tick_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign remaining = remaining_reg;

`ifdef PHASE_TIMER_WARN_EN
  logic warn_reg, warn_next;

  always_comb begin
    warn_next = (state_next == RUN) && (remaining_next != '0) &&
                (remaining_next <= CNT_W'(WARN_CNT));
  end

  always_ff @(posedge clk) begin
    if (rst)
      warn_reg <= 1'b0;
    else
      warn_reg <= warn_next;
  end

  assign warn = warn_reg;
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_phase_timer.sv
// Directed bench for phase_timer (CLK_DIV=5); outputs are sampled 1 ns after each rising edge.
module tb_phase_timer;
  localparam int CLK_DIV  = 5;
  localparam int DIV_W    = 26;
  localparam int CNT_W    = 8;
  localparam int WARN_CNT = 3;
`ifdef PHASE_TIMER_WARN_EN
  localparam bit WARN_EN = 1'b1;
`else
  localparam bit WARN_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic [CNT_W-1:0] duration = '0;
  logic             tick_o, busy, done, warn;
  logic [CNT_W-1:0] remaining;

  int errors = 0;
  int checks = 0;

  phase_timer #(
    .CLK_DIV (CLK_DIV),
    .DIV_W   (DIV_W),
    .CNT_W   (CNT_W),
    .WARN_CNT(WARN_CNT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .duration (duration),
    .pause    (pause),
    .tick_o   (tick_o),
    .busy     (busy),
    .done     (done),
    .remaining(remaining),
    .warn     (warn)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // tick_e < 0 means the tick phase is not pinned down at this point
  task automatic expect_out(input string tag, input int tick_e, input int busy_e,
                            input int done_e, input int rem_e);
    int warn_e;
    warn_e = (WARN_EN && busy_e == 1 && rem_e >= 1 && rem_e <= WARN_CNT) ? 1 : 0;
    if (tick_e >= 0) check({tag, " tick"}, int'(tick_o), tick_e);
    check({tag, " busy"}, int'(busy), busy_e);
    check({tag, " done"}, int'(done), done_e);
    check({tag, " rem"}, int'(remaining), rem_e);
    check({tag, " warn"}, int'(warn), warn_e);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int u;
    bit paused;

    // Reset, then free-running ticks while idle
    step();
    step();
    expect_out("reset", 0, 0, 0, 0);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      expect_out($sformatf("idle k=%0d", k), int'(k % 5 == 0), 0, 0, 0);
    end
    $display("idle: 20 cycles, ticks every 5");

    // Plain phase, duration 3
    duration = 8'd3; start = 1'b1; step(); start = 1'b0;
    expect_out("d3 start", -1, 1, 0, 3);
    for (int k = 1; k <= 15; k++) begin
      step();
      expect_out($sformatf("d3 k=%0d", k), int'(k % 5 == 0), int'(k < 15), int'(k == 15),
                 (k >= 15) ? 0 : 3 - k / 5);
    end
    step();
    expect_out("d3 end", 0, 0, 0, 0);
    $display("phase d=3: done 15 edges after start");

    // Duration 3 with a 7-cycle pause mid-phase
    duration = 8'd3; start = 1'b1; step(); start = 1'b0;
    expect_out("pause start", -1, 1, 0, 3);
    u = 0;
    for (int k = 1; k <= 22; k++) begin
      paused = (k >= 8 && k <= 14);
      pause = paused;
      step();
      if (!paused) u++;
      expect_out($sformatf("pause k=%0d", k), int'(!paused && (u % 5 == 0)), int'(k < 22),
                 int'(k == 22), (u >= 15) ? 0 : 3 - u / 5);
    end
    pause = 1'b0;
    step();
    expect_out("pause end", 0, 0, 0, 0);
    $display("phase d=3 paused 7: done 22 edges after start");

    // Restart: duration 4 aborted after 8 cycles by duration 2
    duration = 8'd4; start = 1'b1; step(); start = 1'b0;
    expect_out("rs first", -1, 1, 0, 4);
    for (int k = 1; k <= 7; k++) begin
      step();
      expect_out($sformatf("rs first k=%0d", k), int'(k % 5 == 0), 1, 0, 4 - k / 5);
    end
    duration = 8'd2; start = 1'b1; step(); start = 1'b0;
    expect_out("rs second", 0, 1, 0, 2);
    for (int k = 1; k <= 10; k++) begin
      step();
      expect_out($sformatf("rs second k=%0d", k), int'(k % 5 == 0), int'(k < 10),
                 int'(k == 10), (k >= 10) ? 0 : 2 - k / 5);
    end
    step();
    expect_out("rs end", 0, 0, 0, 0);
    $display("restart d=4 -> d=2: single done 10 edges after restart");

    // Zero duration completes immediately without busy
    duration = 8'd0; start = 1'b1; step(); start = 1'b0;
    expect_out("d0", -1, 0, 1, 0);
    step();
    expect_out("d0 end", -1, 0, 0, 0);
    $display("phase d=0: done next cycle, busy never high");

    // Reset mid-phase (remaining=2) beats a simultaneous start
    duration = 8'd3; start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    expect_out("pre rst", 1, 1, 0, 2);
    rst = 1'b1; start = 1'b1; step(); rst = 1'b0; start = 1'b0;
    expect_out("mid rst", 0, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step();
      expect_out($sformatf("post rst k=%0d", k), int'(k % 5 == 0), 0, 0, 0);
    end
    $display("reset mid-phase: outputs cleared, no done");

    // Duration 5: warn window when the feature is built
    duration = 8'd5; start = 1'b1; step(); start = 1'b0;
    expect_out("d5 start", -1, 1, 0, 5);
    for (int k = 1; k <= 25; k++) begin
      step();
      expect_out($sformatf("d5 k=%0d", k), int'(k % 5 == 0), int'(k < 25), int'(k == 25),
                 (k >= 25) ? 0 : 5 - k / 5);
    end
    step();
    expect_out("d5 end", 0, 0, 0, 0);
    $display("phase d=5: warn window checked (warn_en=%0d)", WARN_EN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/phase_timer.md
Name: phase_timer

Overview:
- Parametrised successor to the fixed one-shot-rate divider in the traffic-light controller.
- Generates a free-running, pausable tick enable at a configurable rate.
- Counts a loadable number of ticks per light phase and signals phase expiry.
- Sits between the system clock and the controller FSM, which issues one start per phase and waits for done.

Parameters:
- CLK_DIV, 5, clk cycles per tick; legal range 1 .. 2^DIV_W-1 (board build overrides with 50_000_000).
- DIV_W, 26, prescaler counter width.
- CNT_W, 8, phase duration / remaining width.
- WARN_CNT, 3, warning threshold in ticks; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a phase; samples duration.
- duration  in  CNT_W  phase length in ticks.
- pause  in  1  holds prescaler and timer while high.
- tick_o  out  1  one-cycle pulse every CLK_DIV unpaused cycles.
- busy  out  1  high while a phase is running.
- done  out  1  one-cycle pulse at phase expiry.
- remaining  out  CNT_W  ticks left in the current phase.
- warn  out  1  near-expiry flag; optional feature only.

Behaviour:
- Reset: all outputs registered. On rst, presc=CLK_DIV-1; tick_o, busy, done, warn and remaining all 0; state=IDLE. Reset wins over start and pause in the same cycle, including mid-phase, and no done pulse is generated.
- Prescaler:
  - On each edge with pause=0, if presc==0 then presc<=CLK_DIV-1 and tick_o<=1; otherwise presc decrements and tick_o<=0.
  - With pause=1, presc holds and tick_o<=0.
  - Tick period is exactly CLK_DIV unpaused cycles. CLK_DIV=1 gives tick_o permanently high while unpaused.
  - The prescaler runs in every state.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start with duration>0 sets remaining<=duration, presc<=CLK_DIV-1, busy<=1, then goes to RUN. start with duration==0 goes to DONE, with done<=1 and busy stays 0.
  - RUN: on each edge where pause=0 and presc==0 (the tick edge), remaining decrements. On the edge where remaining goes 1->0: busy<=0, done<=1, go to DONE.
  - DONE: lasts one cycle; done<=0, then return to IDLE. start in this cycle is honoured exactly as in IDLE.
- start while RUN: restart. Reload remaining from duration, reset presc to CLK_DIV-1, no done pulse for the aborted phase.
- start and a tick edge in the same cycle: start wins, so there is no decrement.
- Latency: with start sampled at edge E0 and no pause, done and busy=0 are visible after edge E0+duration*CLK_DIV. remaining and tick_o update on the same edges.
- pause in RUN: remaining, presc and state frozen; expiry is delayed by exactly the number of paused cycles.
- remaining is 0 in IDLE and DONE.
- Arithmetic: all counters unsigned and never wrap below 0. duration=2^CNT_W-1 is legal.

Optional Feature:
- Macro: PHASE_TIMER_WARN_EN.
- Defined: warn is registered, high while state==RUN and 1 <= remaining <= WARN_CNT, and low otherwise. warn updates on the same edges as remaining and is cleared on reset and restart. If the reloaded duration<=WARN_CNT, warn is high from the cycle after start.
- Not defined: warn is tied 0, no comparator logic is generated, and all other behaviour is identical.

Test Plan:
- Reset then idle 20 cycles with CLK_DIV=5 -> tick_o pulses every 5 cycles, first after the 5th edge post-reset; busy=done=remaining=0.
- start with duration=3 -> remaining steps 3,2,1,0 at ticks; busy high 15 cycles; done single pulse exactly 15 edges after start.
- duration=3, pause high 7 cycles mid-phase -> done at 22 edges after start; no tick_o while paused; remaining frozen.
- Restart: start duration=4, then start duration=2 after 8 cycles -> no done for the first phase; done 10 edges after the second start.
- start duration=0 -> done pulse next cycle; busy never high. rst asserted mid-RUN with remaining=2 -> all outputs 0 next cycle, no done.
- PHASE_TIMER_WARN_EN with WARN_CNT=3, duration=5 -> warn rises when remaining becomes 3 and falls with done; without the macro, warn stays 0 throughout.
